fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch (F) stage producer for the F->D pipeline register: owns the PC,
//  fetches from instruction memory over a req/ack handshake, presents instr_F/PC_F/PC8_F
//  and holds them until the D register accepts (D_en). Sits between IM and the D register;
//  takes branch/jump redirects resolved in D, with MIPS delay-slot semantics.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC loaded on reset
//  IMEM_BASE  32'h0000_3000  lowest legal fetch address
//  IMEM_SIZE  32'h0000_4000  legal fetch window size, bytes
//  NOP_INSTR  32'h0000_0000  bubble/exception instruction word (sll $0,$0,0)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  D_en        in   1   D register loads this cycle (no stall)
//  br_taken    in   1   redirect pulse from D (branch/jump taken)
//  br_target   in   32  redirect target
//  imem_req    out  1   fetch request valid
//  imem_addr   out  32  fetch word address (= pc_q)
//  imem_ack    in   1   imem_rdata valid this cycle
//  imem_rdata  in   32  fetched instruction
//  F_valid     out  1   instr_F/PC_F/PC8_F valid
//  F_adel      out  1   fetch address error on presented PC
//  instr_F     out  32  instruction to D register
//  PC_F        out  32  PC of instr_F
//  PC8_F       out  32  PC_F + 8 (link address)
// BEHAVIOUR
//  - State: REQ (request outstanding) | HOLD (instr buffered, awaiting D_en) | ERR (bad PC).
//  - Reset (async, reset=0): state=REQ, pc_q=RESET_PC, pend_v=0, buf=NOP_INSTR;
//    all outputs derive from state: imem_req=1, F_valid=0, F_adel=0, instr_F=NOP_INSTR,
//    PC_F=RESET_PC, PC8_F=RESET_PC+8. Reset mid-request drops it; IM shares reset.
//  - Always: PC_F=pc_q, PC8_F=pc_q+8 (mod 2^32), imem_addr=pc_q.
//  - bad_pc = pc_q[1:0]!=0 | pc_q<IMEM_BASE | pc_q>=IMEM_BASE+IMEM_SIZE (entered via next-PC).
//  - REQ: imem_req=1. F_valid=imem_ack, instr_F = ack ? imem_rdata : NOP_INSTR (same-cycle
//    pass-through). ack&D_en -> advance (stay REQ on new PC, or ERR if bad).
//    ack&!D_en -> buf<=imem_rdata, go HOLD. !ack -> stay.
//  - HOLD: imem_req=0, F_valid=1, instr_F=buf. D_en -> advance; else hold, outputs stable.
//  - ERR: imem_req=0, F_valid=1, F_adel=1, instr_F=NOP_INSTR. D_en -> advance.
//  - advance: pc_q <= br_taken ? br_target : pend_v ? pend_pc : pc_q+4; pend_v<=0;
//    state <= bad(next) ? ERR : REQ.
//  - Redirect without advance: pend_pc<=br_target, pend_v<=1 (later pulse overwrites).
//    The instruction presented/in flight is the delay slot: never killed.
//  - D_en with F_valid=0 is not a consumption (D register captures bubble NOP).
//  - imem_ack outside REQ ignored. Throughput 1 instr/cycle with 0-wait IM.
//  - pc_q+4 wraps at 2^32 and then faults via range check (ERR).
// STRUCTURE
//  - Shared `define header (mips_defs.v): RESET_PC, IMEM_BASE/SIZE, NOP_INSTR, state codes.
//  - One sub-module: fetch_npc (combinational next-PC mux + range/alignment check).
//  - Remainder: state register, pc_q, buf, pend_v/pend_pc in this module.
// TESTING
//  - Reset, 0-wait IM, D_en=1: PC_F 0x3000,0x3004,0x3008 on consecutive cycles;
//    imem_req=1 each; PC8_F=PC_F+8.
//  - IM ack at 3rd cycle, D_en=0 for 2 cycles after ack: state HOLD, instr_F=buffered word,
//    PC_F=0x3000 stable, imem_req=0; D_en=1 -> next request at 0x3004.
//  - br_taken(target 0x3100) while delay slot 0x3004 presented, D_en=1: 0x3004 consumed,
//    next PC_F=0x3100.
//  - br_taken(0x3200) while 0x3008 request waiting ack: pend_v=1; after 0x3008 consumed,
//    PC_F=0x3200.
//  - br_target=0x3002: after delay slot, F_valid=1, F_adel=1, instr_F=0, imem_req=0;
//    br_target=0x0000_1000 same response (out of range).
//  - Assert reset=0 mid-HOLD asynchronously: outputs to reset values before next clk edge;
//    release -> fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - default reset PC, legal fetch window and bubble instruction
//   - fetch FSM state encoding
//   - pc_in_window(): range check used by the next-PC logic
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE_DEF = 32'h0000_3000;
    localparam logic [31:0] IMEM_SIZE_DEF = 32'h0000_4000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] LINK_OFS = 32'd8;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_t;

    // Window limit is computed in 33 bits so base+size cannot wrap.
    function automatic logic pc_in_window(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
        logic [32:0] lim;
        lim = {1'b0, base} + {1'b0, size};
        return ({1'b0, pc} >= {1'b0, base}) && ({1'b0, pc} < lim);
    endfunction

endpackage

// File: rtl/fetch_npc.sv
// Next-PC selection and address check for the fetch stage.
// Ports:
//   pc_q      in   current fetch PC
//   br_taken  in   redirect this cycle
//   br_target in   redirect target
//   pend_v    in   a redirect is pending from an earlier cycle
//   pend_pc   in   pending redirect target
//   npc       out  PC to load on the next advance
//   npc_bad   out  npc is misaligned or outside the instruction window
module fetch_npc
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
    parameter logic [31:0] IMEM_SIZE = IMEM_SIZE_DEF
) (
    input  logic [31:0] pc_q,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        pend_v,
    input  logic [31:0] pend_pc,
    output logic [31:0] npc,
    output logic        npc_bad
);

    // A same-cycle redirect wins over an older pending one.
    always_comb begin
        if (br_taken)
            npc = br_target;
        else if (pend_v)
            npc = pend_pc;
        else
            npc = pc_q + PC_STEP;  // wraps mod 2^32; the window check then faults it
    end

    assign npc_bad = (npc[1:0] != 2'b00) || !pc_in_window(npc, IMEM_BASE, IMEM_SIZE);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// holds instr_F/PC_F/PC8_F until the D register accepts them (D_en).
// Redirects from D follow delay-slot semantics: the presented or in-flight
// instruction is never killed; a redirect that arrives while nothing is being
// consumed is remembered and applied on the next advance.
//
//   state | meaning
//   ------+----------------------------------------------------
//   REQ   | request at pc_q outstanding, ack passes straight through
//   HOLD  | fetched word buffered, waiting for D_en
//   ERR   | pc_q is misaligned/out of window, presenting a NOP with F_adel
//
// Ports:
//   clk, reset                clock, async active-low reset
//   D_en                      D register loads this cycle
//   br_taken, br_target       redirect from D
//   imem_req, imem_addr       fetch request / word address
//   imem_ack, imem_rdata      fetch response
//   F_valid, F_adel           presented instruction valid / address error
//   instr_F, PC_F, PC8_F      instruction, its PC, PC+8 link address
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
    parameter logic [31:0] IMEM_SIZE = IMEM_SIZE_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_en,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        F_valid,
    output logic        F_adel,
    output logic [31:0] instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC8_F
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_buf;
    logic         pend_v;
    logic [31:0]  pend_pc;
    logic [31:0]  npc;
    logic         npc_bad;
    logic         advance;

    fetch_npc #(
        .IMEM_BASE (IMEM_BASE),
        .IMEM_SIZE (IMEM_SIZE)
    ) u_npc (
        .pc_q      (pc_q),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pend_v    (pend_v),
        .pend_pc   (pend_pc),
        .npc       (npc),
        .npc_bad   (npc_bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_REQ;
        else
            state_q <= state_d;
    end

    // advance = the presented instruction is consumed by D this cycle.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    if (D_en)
                        advance = 1'b1;
                    else
                        state_d = ST_HOLD;
                end
            end
            ST_HOLD, ST_ERR: begin
                if (D_en)
                    advance = 1'b1;
            end
            default: state_d = ST_REQ;
        endcase
        if (advance)
            state_d = npc_bad ? ST_ERR : ST_REQ;
    end

    always_comb begin
        imem_req = 1'b0;
        F_valid  = 1'b0;
        F_adel   = 1'b0;
        instr_F  = NOP_INSTR;
        case (state_q)
            ST_REQ: begin
                imem_req = 1'b1;
                F_valid  = imem_ack;
                instr_F  = imem_ack ? imem_rdata : NOP_INSTR;
            end
            ST_HOLD: begin
                F_valid = 1'b1;
                instr_F = instr_buf;
            end
            ST_ERR: begin
                F_valid = 1'b1;
                F_adel  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            instr_buf <= NOP_INSTR;
            pend_v    <= 1'b0;
            pend_pc   <= 32'h0;
        end else begin
            if (advance) begin
                pc_q   <= npc;
                pend_v <= 1'b0;
            end else if (br_taken) begin
                pend_pc <= br_target;
                pend_v  <= 1'b1;
            end
            if (state_q == ST_REQ && imem_ack && !D_en)
                instr_buf <= imem_rdata;
        end
    end

    assign imem_addr = pc_q;
    assign PC_F      = pc_q;
    assign PC8_F     = pc_q + LINK_OFS;

endmodule
